// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared sizes, frame layout and state encoding for nn_operand_loader
package nn_pkg;

    localparam int DW    = 5;
    localparam int N_IN  = 4;
    localparam int N_HID = 4;
    localparam int N_OUT = 2;
    localparam int CW    = 5;

`ifdef NN_LOADER_CKSUM_EN
    localparam int FRAME_WORDS = 29;
`else
    localparam int FRAME_WORDS = 28;
`endif

    localparam logic [CW-1:0] X_BASE     = 5'd0;
    localparam logic [CW-1:0] WIH_BASE   = 5'd4;
    localparam logic [CW-1:0] WHO_BASE   = 5'd20;
    localparam logic [CW-1:0] OPND_WORDS = 5'd28;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CHECK = 2'd1,
        ST_FIRE  = 2'd2,
        ST_WAIT  = 2'd3
    } ld_state_e;

endpackage

// File: rtl/nn_operand_loader.sv
// rtl/nn_operand_loader.sv - assembles a streamed operand frame and hands it to the NN core
// NN_LOADER_CKSUM_EN appends an XOR check word, a CHECK state and the err_cksum output.
module nn_operand_loader
    import nn_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      soft_clr,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DW-1:0]             s_data,
    output logic [N_IN*DW-1:0]        x_flat,
    output logic [N_IN*N_HID*DW-1:0]  w_ih_flat,
    output logic [N_HID*N_OUT*DW-1:0] w_ho_flat,
    output logic                      in_ready,
    input  logic                      out0_ready,
    input  logic                      out1_ready,
    output logic                      busy,
`ifdef NN_LOADER_CKSUM_EN
    output logic                      err_cksum,
`endif
    output logic                      err_tmo
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    ld_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [TW-1:0] tmo_q;
    logic          d0_q, d1_q;
    logic          s_ready_q, in_ready_q, busy_q, err_tmo_q;

    logic [DW-1:0] x_q   [N_IN];
    logic [DW-1:0] wih_q [N_IN*N_HID];
    logic [DW-1:0] who_q [N_HID*N_OUT];

    logic          accept, wr, last_word, done_now, tmo_hit, tmo_fire;
    logic          d0_n, d1_n;
    logic [1:0]    x_idx;
    logic [3:0]    wih_idx;
    logic [2:0]    who_idx;

`ifdef NN_LOADER_CKSUM_EN
    logic [DW-1:0] acc_q, cks_q;
    logic          cks_bad, err_cksum_q;
`endif

    always_comb begin
        accept    = s_ready_q & s_valid;
        wr        = accept & ~soft_clr;
        last_word = (cnt_q == CW'(FRAME_WORDS - 1));
        d0_n      = d0_q | out0_ready;
        d1_n      = d1_q | out1_ready;
        done_now  = d0_n & d1_n;
        tmo_hit   = (tmo_q == TW'(TIMEOUT_CYC - 1));
        x_idx     = 2'(cnt_q - X_BASE);
        wih_idx   = 4'(cnt_q - WIH_BASE);
        who_idx   = 3'(cnt_q - WHO_BASE);

        state_d   = state_q;
        tmo_fire  = 1'b0;
`ifdef NN_LOADER_CKSUM_EN
        cks_bad   = 1'b0;
`endif
        case (state_q)
            ST_LOAD: begin
                if (accept && last_word) begin
`ifdef NN_LOADER_CKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_FIRE;
`endif
                end
            end
`ifdef NN_LOADER_CKSUM_EN
            ST_CHECK: begin
                if (cks_q == acc_q) begin
                    state_d = ST_FIRE;
                end else begin
                    state_d = ST_LOAD;
                    cks_bad = 1'b1;
                end
            end
`endif
            ST_FIRE: state_d = ST_WAIT;
            ST_WAIT: begin
                // done beats a coincident timeout
                if (done_now) begin
                    state_d = ST_LOAD;
                end else if (tmo_hit) begin
                    state_d  = ST_LOAD;
                    tmo_fire = 1'b1;
                end
            end
            default: state_d = ST_LOAD;
        endcase

        if (soft_clr) begin
            state_d  = ST_LOAD;
            tmo_fire = 1'b0;
`ifdef NN_LOADER_CKSUM_EN
            cks_bad  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD;
            cnt_q      <= '0;
            tmo_q      <= '0;
            d0_q       <= 1'b0;
            d1_q       <= 1'b0;
            s_ready_q  <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            err_tmo_q  <= 1'b0;
            for (int i = 0; i < N_IN; i++)        x_q[i]   <= '0;
            for (int i = 0; i < N_IN*N_HID; i++)  wih_q[i] <= '0;
            for (int i = 0; i < N_HID*N_OUT; i++) who_q[i] <= '0;
`ifdef NN_LOADER_CKSUM_EN
            acc_q       <= '0;
            cks_q       <= '0;
            err_cksum_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            s_ready_q  <= (state_d == ST_LOAD);
            busy_q     <= (state_d == ST_FIRE) || (state_d == ST_WAIT);
            in_ready_q <= (state_q == ST_FIRE) && !soft_clr;
            err_tmo_q  <= tmo_fire;
            // sticky flags only accumulate in WAIT, so FIRE-cycle pulses are dropped
            d0_q       <= (state_q == ST_WAIT) ? d0_n : 1'b0;
            d1_q       <= (state_q == ST_WAIT) ? d1_n : 1'b0;
            tmo_q      <= (state_q == ST_WAIT) ? tmo_q + 1'b1 : '0;

            if (soft_clr || (accept && last_word)) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (wr) begin
                case (1'b1)
                    (cnt_q < WIH_BASE):   x_q[x_idx]     <= s_data;
                    (cnt_q < WHO_BASE):   wih_q[wih_idx] <= s_data;
                    (cnt_q < OPND_WORDS): who_q[who_idx] <= s_data;
                    default: ;
                endcase
`ifdef NN_LOADER_CKSUM_EN
                if (cnt_q < OPND_WORDS) begin
                    acc_q <= (cnt_q == '0) ? s_data : (acc_q ^ s_data);
                end else begin
                    cks_q <= s_data;
                end
`endif
            end
`ifdef NN_LOADER_CKSUM_EN
            err_cksum_q <= cks_bad;
`endif
        end
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_x
        assign x_flat[i*DW +: DW] = x_q[i];
    end
    for (genvar i = 0; i < N_IN*N_HID; i++) begin : g_wih
        assign w_ih_flat[i*DW +: DW] = wih_q[i];
    end
    for (genvar i = 0; i < N_HID*N_OUT; i++) begin : g_who
        assign w_ho_flat[i*DW +: DW] = who_q[i];
    end

    assign s_ready  = s_ready_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign err_tmo  = err_tmo_q;
`ifdef NN_LOADER_CKSUM_EN
    assign err_cksum = err_cksum_q;
`endif

endmodule

// File: tb/tb_nn_operand_loader.sv
// tb/tb_nn_operand_loader.sv - scoreboard bench for nn_operand_loader (NN_LOADER_CKSUM_EN aware)
module tb_nn_operand_loader;
    import nn_pkg::*;

    localparam int TMO = 64;
    localparam int XW  = N_IN*DW;
    localparam int IW  = N_IN*N_HID*DW;
    localparam int OW  = N_HID*N_OUT*DW;
`ifdef NN_LOADER_CKSUM_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, soft_clr = 1'b0, s_valid = 1'b0;
    logic          out0_ready = 1'b0, out1_ready = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready, in_ready, busy, err_tmo, err_cksum;
    logic [XW-1:0] x_flat;
    logic [IW-1:0] w_ih_flat;
    logic [OW-1:0] w_ho_flat;
`ifndef NN_LOADER_CKSUM_EN
    assign err_cksum = 1'b0;
`endif

    nn_operand_loader #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .x_flat(x_flat), .w_ih_flat(w_ih_flat), .w_ho_flat(w_ho_flat),
        .in_ready(in_ready), .out0_ready(out0_ready), .out1_ready(out1_ready),
        .busy(busy),
`ifdef NN_LOADER_CKSUM_EN
        .err_cksum(err_cksum),
`endif
        .err_tmo(err_tmo)
    );

    typedef enum int {EV_FIRE, EV_TMO, EV_CKS} ev_kind_e;
    typedef struct {
        ev_kind_e      kind;
        int            cyc;
        logic [XW-1:0] x;
        logic [IW-1:0] wih;
        logic [OW-1:0] who;
    } ev_t;

    ev_t           sb[$];
    int            checks = 0, errors = 0, cyc = 0;
    logic [DW-1:0] frame [28];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ev_t make_ev(input ev_kind_e k, input int c);
        ev_t e;
        e.kind = k; e.cyc = c; e.x = '0; e.wih = '0; e.who = '0;
        for (int i = 0; i < 4; i++) begin
            e.x[i*DW +: DW] = frame[i];
            for (int j = 0; j < 4; j++) e.wih[(j*4+i)*DW +: DW] = frame[4 + 4*j + i];
        end
        for (int j = 0; j < 4; j++)
            for (int k2 = 0; k2 < 2; k2++) e.who[(k2*4+j)*DW +: DW] = frame[20 + 4*k2 + j];
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        ev_t      e;
        ev_kind_e k;
        if (rst_n && (in_ready || err_tmo || err_cksum)) begin
            k = in_ready ? EV_FIRE : (err_tmo ? EV_TMO : EV_CKS);
            if (sb.size() == 0) begin
                check("unexpected_event", 128'(k) + 1, 0);
            end else begin
                e = sb.pop_front();
                check("event_kind", k, e.kind);
                check("event_cycle", cyc, e.cyc);
                if (k == EV_FIRE) begin
                    check("x_flat", x_flat, e.x);
                    check("w_ih_flat", w_ih_flat, e.wih);
                    check("w_ho_flat", w_ho_flat, e.who);
                end
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic send_word(input logic [DW-1:0] d, output int acc);
        int n = 0;
        @(negedge clk);
        s_valid = 1'b1; s_data = d;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_bound", 0, 1);
        acc = cyc;
    endtask

    // returns at the negedge one cycle after the last accept
    task automatic send_frame(input bit gap, input bit flip, input bit exp_tmo, output int ir);
        int            acc;
        logic [DW-1:0] ck;
        ck = '0;
        for (int i = 0; i < 28; i++) begin
            send_word(frame[i], acc);
            ck ^= frame[i];
            if (gap && i < 27) begin
                @(negedge clk);
                s_valid = 1'b0;
            end
        end
`ifdef NN_LOADER_CKSUM_EN
        send_word(flip ? (ck ^ 5'b00100) : ck, acc);
`endif
        ir = acc + LAT;
        if (flip) begin
            sb.push_back(make_ev(EV_CKS, acc + 2));
        end else begin
            sb.push_back(make_ev(EV_FIRE, ir));
            if (exp_tmo) sb.push_back(make_ev(EV_TMO, ir + TMO));
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic respond(input int ir, input int t0, input int t1);
        int last;
        last = (t0 > t1) ? t0 : t1;
        for (int c = ir; c <= ir + last; c++) begin
            goto(c);
            out0_ready = (c == ir + t0);
            out1_ready = (c == ir + t1);
            s_valid    = (c < ir + last);
            check("wait_s_ready", s_ready, 0);
            check("wait_busy", busy, 1);
        end
        goto(ir + last + 1);
        out0_ready = 1'b0; out1_ready = 1'b0;
        check("load_s_ready", s_ready, 1);
        check("load_busy", busy, 0);
    endtask

    task automatic fill_const(input logic [DW-1:0] v);
        for (int i = 0; i < 28; i++) frame[i] = v;
    endtask

    initial begin
        int            ir, acc;
        logic [XW-1:0] exp_x;

        repeat (3) @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_err_tmo", err_tmo, 0);
        check("rst_x_flat", x_flat, 0);
        check("rst_w_ih_flat", w_ih_flat, 0);
        check("rst_w_ho_flat", w_ho_flat, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_ready", s_ready, 1);

        fill_const(5'b01111);
        send_frame(0, 0, 0, ir);
        respond(ir, 2, 2);

        fill_const(5'b10000);
        send_frame(1, 0, 0, ir);
        respond(ir, 1, 4);

        for (int i = 0; i < 28; i++) frame[i] = 5'(i);
        send_frame(0, 0, 0, ir);
        goto(ir - 1);
        out0_ready = 1'b1; out1_ready = 1'b1;
        respond(ir, 3, 7);

        for (int i = 0; i < 28; i++) frame[i] = 5'(i) ^ 5'h15;
        send_frame(0, 0, 1, ir);
        goto(ir + TMO - 1);
        check("tmo_busy_before", busy, 1);
        goto(ir + TMO);
        check("tmo_busy_after", busy, 0);
        check("tmo_s_ready_after", s_ready, 1);

        fill_const(5'b00001);
        send_frame(0, 0, 0, ir);
        respond(ir, TMO - 1, TMO - 1);

        fill_const(5'b01010);
        for (int i = 0; i < 13; i++) send_word(5'b00111, acc);
        @(negedge clk);
        s_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("midrst_x_flat", x_flat, 0);
        rst_n = 1'b1;
        send_frame(0, 0, 0, ir);
        respond(ir, 1, 1);

        for (int i = 0; i < 13; i++) send_word(5'b00110, acc);
        @(negedge clk);
        s_valid = 1'b0; soft_clr = 1'b1;
        @(negedge clk);
        soft_clr = 1'b0;
        for (int i = 0; i < 4; i++) exp_x[i*DW +: DW] = 5'b00110;
        check("softclr_retain_x", x_flat, exp_x);
        fill_const(5'b11001);
        send_frame(0, 0, 0, ir);
        respond(ir, 2, 1);

`ifdef NN_LOADER_CKSUM_EN
        for (int i = 0; i < 28; i++) frame[i] = 5'(3 * i + 1);
        send_frame(0, 1, 0, ir);
        goto(ir);
        check("cks_bad_s_ready", s_ready, 1);
        check("cks_bad_busy", busy, 0);
        send_frame(0, 0, 0, ir);
        respond(ir, 1, 2);
`endif

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
